// File: rtl/block_plotter.sv
// Draws a SIZE x SIZE square per request as a one-pixel-per-cycle stream for a VGA adapter.
// Define BLOCK_PLOTTER_ERASE_PREV_EN to erase the previous square in BG_COLOUR before each draw.
module block_plotter #(
    parameter int         SIZE      = 2,
    parameter int         Y_LIMIT   = 120,
    parameter logic [2:0] BG_COLOUR = 3'b011
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [6:0] req_x,
    input  logic [6:0] req_y,
    input  logic [2:0] req_colour,
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic [6:0] pix_x,
    output logic [6:0] pix_y,
    output logic [2:0] pix_colour,
    output logic       pix_plot
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ERASE = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [2:0] LAST  = 3'(SIZE - 1);

    logic [1:0] state, next_state;
    logic [2:0] dx, dy, next_dx, next_dy;
    logic [6:0] lat_x, lat_y;
    logic [2:0] lat_colour;
    logic       start_erase;
    logic [6:0] base_x, base_y;
    logic [2:0] base_colour;
    logic [7:0] sum_x, sum_y;
    logic       next_plot;

`ifdef BLOCK_PLOTTER_ERASE_PREV_EN
    logic [6:0] prev_x, prev_y;
    logic       prev_valid;
    assign start_erase = prev_valid;
`else
    assign start_erase = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Row-major scan: dx wraps fastest, then dy; ERASE chains into DRAW.
    always_comb begin
        next_state = state;
        next_dx    = dx;
        next_dy    = dy;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    next_state = start_erase ? ERASE : DRAW;
                    next_dx    = 3'd0;
                    next_dy    = 3'd0;
                end
            end
            ERASE, DRAW: begin
                if (dx == LAST) begin
                    next_dx = 3'd0;
                    if (dy == LAST) begin
                        next_dy    = 3'd0;
                        next_state = (state == ERASE) ? DRAW : DONE;
                    end else begin
                        next_dy = dy + 3'd1;
                    end
                end else begin
                    next_dx = dx + 3'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pixels are computed for the upcoming cycle so the outputs can be registered
    // while the first pixel still appears the cycle after acceptance.
    always_comb begin
        base_x      = (state == IDLE) ? req_x      : lat_x;
        base_y      = (state == IDLE) ? req_y      : lat_y;
        base_colour = (state == IDLE) ? req_colour : lat_colour;
`ifdef BLOCK_PLOTTER_ERASE_PREV_EN
        if (next_state == ERASE) begin
            base_x = prev_x;
            base_y = prev_y;
        end
`endif
        if (next_state == ERASE) begin
            base_colour = BG_COLOUR;
        end
        sum_x     = {1'b0, base_x} + {5'b0, next_dx};
        sum_y     = {1'b0, base_y} + {5'b0, next_dy};
        next_plot = ((next_state == ERASE) || (next_state == DRAW)) &&
                    !sum_x[7] && (sum_y < 8'(Y_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            dx         <= 3'd0;
            dy         <= 3'd0;
            pix_plot   <= 1'b0;
            pix_x      <= 7'd0;
            pix_y      <= 7'd0;
            pix_colour <= 3'd0;
        end else begin
            state    <= next_state;
            dx       <= next_dx;
            dy       <= next_dy;
            pix_plot <= next_plot;
            if (next_plot) begin
                pix_x      <= sum_x[6:0];
                pix_y      <= sum_y[6:0];
                pix_colour <= base_colour;
            end
        end
    end

    // NOTE: request latches carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lat_x      <= req_x;
            lat_y      <= req_y;
            lat_colour <= req_colour;
        end
    end

`ifdef BLOCK_PLOTTER_ERASE_PREV_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_x     <= 7'd0;
            prev_y     <= 7'd0;
            prev_valid <= 1'b0;
        end else if (state == DONE) begin
            prev_x     <= lat_x;
            prev_y     <= lat_y;
            prev_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_block_plotter.sv
// Directed bench for block_plotter (SIZE=2, Y_LIMIT=120); follows BLOCK_PLOTTER_ERASE_PREV_EN.
module tb_block_plotter;

`ifdef BLOCK_PLOTTER_ERASE_PREV_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif
    localparam int         SIZE = 2;
    localparam logic [2:0] BG   = 3'b011;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_x = 7'd0;
    logic [6:0] req_y = 7'd0;
    logic [2:0] req_colour = 3'd0;
    logic       req_ready, busy, done, pix_plot;
    logic [6:0] pix_x, pix_y;
    logic [2:0] pix_colour;

    int n_checks = 0;
    int n_fail   = 0;

    block_plotter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .busy       (busy),
        .done       (done),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_plot   (pix_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All helpers run at a falling edge; outputs are stable there.
    task automatic send(input string tag, input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_x      = x;
        req_y      = y;
        req_colour = c;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic expect_pix(input string tag, input logic plot,
                              input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
        check(tag, 32'({busy, pix_plot, done, pix_x, pix_y, pix_colour}),
              32'({1'b1, plot, 1'b0, x, y, c}));
        @(negedge clk);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'({busy, done, pix_plot, req_ready}), 32'b1100);
        @(negedge clk);
        check({tag, "_idle"}, 32'({busy, done, req_ready}), 32'b001);
    endtask

    task automatic expect_reset_state(input string tag);
        check(tag, 32'({req_ready, busy, done, pix_plot, pix_x, pix_y, pix_colour}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0}));
    endtask

    initial begin
        logic [31:0] exp_first;
        logic [6:0]  prev_acc_x;
        int          next_acc;
        int          acc_count;
        bit          pending;
        bit          idle_seen;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        expect_reset_state("reset");
        resetn = 1'b1;

        // Basic draw of (8,8) in 101
        send("a", 7'd8, 7'd8, 3'b101);
        expect_pix("a_p0", 1'b1, 7'd8, 7'd8, 3'b101);
        expect_pix("a_p1", 1'b1, 7'd9, 7'd8, 3'b101);
        expect_pix("a_p2", 1'b1, 7'd8, 7'd9, 3'b101);
        expect_pix("a_p3", 1'b1, 7'd9, 7'd9, 3'b101);
        expect_done("a");

        // Second request at (10,8): erases the first square when the feature is built in
        send("b", 7'd10, 7'd8, 3'b101);
        if (ERASE_EN) begin
            expect_pix("b_e0", 1'b1, 7'd8, 7'd8, BG);
            expect_pix("b_e1", 1'b1, 7'd9, 7'd8, BG);
            expect_pix("b_e2", 1'b1, 7'd8, 7'd9, BG);
            expect_pix("b_e3", 1'b1, 7'd9, 7'd9, BG);
        end
        expect_pix("b_p0", 1'b1, 7'd10, 7'd8, 3'b101);
        expect_pix("b_p1", 1'b1, 7'd11, 7'd8, 3'b101);
        expect_pix("b_p2", 1'b1, 7'd10, 7'd9, 3'b101);
        expect_pix("b_p3", 1'b1, 7'd11, 7'd9, 3'b101);
        expect_done("b");

        // Clipping at the right and bottom edges; outputs hold while suppressed
        send("clip", 7'd127, 7'd119, 3'b110);
        if (ERASE_EN) begin
            expect_pix("clip_e0", 1'b1, 7'd10, 7'd8, BG);
            expect_pix("clip_e1", 1'b1, 7'd11, 7'd8, BG);
            expect_pix("clip_e2", 1'b1, 7'd10, 7'd9, BG);
            expect_pix("clip_e3", 1'b1, 7'd11, 7'd9, BG);
        end
        expect_pix("clip_p0", 1'b1, 7'd127, 7'd119, 3'b110);
        expect_pix("clip_p1", 1'b0, 7'd127, 7'd119, 3'b110);
        expect_pix("clip_p2", 1'b0, 7'd127, 7'd119, 3'b110);
        expect_pix("clip_p3", 1'b0, 7'd127, 7'd119, 3'b110);
        expect_done("clip");

        // Reset during the second DRAW pixel aborts the request
        send("abort", 7'd20, 7'd30, 3'b010);
        if (ERASE_EN) begin
            expect_pix("abort_e0", 1'b1, 7'd127, 7'd119, BG);
            expect_pix("abort_e1", 1'b0, 7'd127, 7'd119, BG);
            expect_pix("abort_e2", 1'b0, 7'd127, 7'd119, BG);
            expect_pix("abort_e3", 1'b0, 7'd127, 7'd119, BG);
        end
        expect_pix("abort_p0", 1'b1, 7'd20, 7'd30, 3'b010);
        check("abort_p1", 32'({busy, pix_plot, pix_x, pix_y, pix_colour}),
              32'({1'b1, 1'b1, 7'd21, 7'd30, 3'b010}));
        resetn = 1'b0;
        @(negedge clk);
        expect_reset_state("abort_rst");
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_quiet", 32'({done, pix_plot, busy}), 32'b000);
        end

        // First request after the abort must not erase
        send("post", 7'd40, 7'd50, 3'b001);
        expect_pix("post_p0", 1'b1, 7'd40, 7'd50, 3'b001);
        expect_pix("post_p1", 1'b1, 7'd41, 7'd50, 3'b001);
        expect_pix("post_p2", 1'b1, 7'd40, 7'd51, 3'b001);
        expect_pix("post_p3", 1'b1, 7'd41, 7'd51, 3'b001);
        expect_done("post");

        // Held req_valid with changing coordinates: acceptance only in IDLE cycles
        resetn = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        next_acc   = 0;
        acc_count  = 0;
        pending    = 1'b0;
        prev_acc_x = 7'd0;
        exp_first  = 32'd0;
        for (int i = 0; i < 24; i++) begin
            req_valid  = 1'b1;
            req_x      = 7'(i);
            req_y      = 7'd10;
            req_colour = 3'b100;
            if (pending) begin
                check("held_first", 32'({pix_plot, pix_x, pix_y, pix_colour}), exp_first);
                pending = 1'b0;
            end
            check("held_ready", 32'(req_ready), 32'(i == next_acc));
            if (i == next_acc) begin
                if (ERASE_EN && acc_count > 0) begin
                    exp_first = 32'({1'b1, prev_acc_x, 7'd10, BG});
                    next_acc  = i + 2 * SIZE * SIZE + 2;
                end else begin
                    exp_first = 32'({1'b1, 7'(i), 7'd10, 3'b100});
                    next_acc  = i + SIZE * SIZE + 2;
                end
                prev_acc_x = 7'(i);
                pending    = 1'b1;
                acc_count++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        idle_seen = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            if (req_ready) idle_seen = 1'b1;
            else @(negedge clk);
        end
        check("final_idle", 32'(idle_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_plotter.md
BLOCK_PLOTTER -- requirements
Module: block_plotter

Interface
REQ-001 Parameter SIZE, default 2: edge length in pixels of the square drawn per request (1..8).
REQ-002 Parameter Y_LIMIT, default 120: first invalid row; rows >= Y_LIMIT are never plotted.
REQ-003 Parameter BG_COLOUR, default 3'b011: colour used for erase writes.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  request to draw a square; x/y/colour are sampled when req_valid && req_ready.
REQ-007 req_x  in  7  top-left column of the square.
REQ-008 req_y  in  7  top-left row of the square.
REQ-009 req_colour  in  3  fill colour.
REQ-010 req_ready  out  1  block is idle and accepts a request this cycle.
REQ-011 busy  out  1  high while a request is being serviced.
REQ-012 done  out  1  one-cycle pulse after the last pixel of a request.
REQ-013 pix_x  out  7  pixel column to the VGA adapter.
REQ-014 pix_y  out  7  pixel row to the VGA adapter.
REQ-015 pix_colour  out  3  pixel colour to the VGA adapter.
REQ-016 pix_plot  out  1  write strobe to the VGA adapter, one pixel per high cycle.

Function
REQ-017 The FSM SHALL have states IDLE, ERASE, DRAW and DONE; req_ready = (state == IDLE); busy = (state != IDLE).
REQ-018 On acceptance in IDLE, the block SHALL latch x, y and colour and go to ERASE if the erase feature is compiled in and prev_valid = 1; otherwise it SHALL go to DRAW.
REQ-019 ERASE and DRAW SHALL each last exactly SIZE*SIZE cycles and scan row-major (dx 0..SIZE-1 fastest, then dy), with one pixel per cycle.
REQ-020 Pixel outputs SHALL be registered: the first pix_plot is high in the cycle after acceptance.
REQ-021 DRAW pixels SHALL be at (latched x + dx, latched y + dy) with the latched colour.
REQ-022 ERASE pixels SHALL be at (prev_x + dx, prev_y + dy) with BG_COLOUR.
REQ-023 Sums SHALL be computed 8 bits wide; a pixel whose column sum exceeds 127 or whose row sum is >= Y_LIMIT SHALL produce pix_plot = 0 for that cycle, still consume the cycle, and never wrap.
REQ-024 After the last DRAW cycle, the FSM SHALL enter DONE for one cycle: done = 1, pix_plot = 0, and latched x/y copied to prev_x/prev_y with prev_valid = 1. It then returns to IDLE.
REQ-025 Each request SHALL take SIZE*SIZE + 1 cycles from acceptance to the done pulse, or 2*SIZE*SIZE + 1 when erasing.
REQ-026 While busy, req_valid SHALL be ignored and inputs SHALL not be sampled; there is no queueing.
REQ-027 A request presented in the same cycle that DONE returns to IDLE SHALL not be accepted until the following cycle, because req_ready is low in DONE.
REQ-028 pix_x, pix_y and pix_colour SHALL hold their last values while pix_plot = 0.

Reset
REQ-029 While resetn = 0 at a clock edge, the block SHALL set state = IDLE, pix_plot = 0, pix_x = 0, pix_y = 0, pix_colour = 0, done = 0, prev_valid = 0, prev_x = 0 and prev_y = 0; req_ready reads 1 and busy reads 0.
REQ-030 A reset asserted mid-ERASE or mid-DRAW SHALL abort the request: no further pixels, no done pulse, and prev_valid cleared.

Configuration
REQ-031 Macro BLOCK_PLOTTER_ERASE_PREV_EN defined: the ERASE state and prev_x/prev_y/prev_valid storage SHALL be present per REQ-018/022/024.
REQ-032 Macro BLOCK_PLOTTER_ERASE_PREV_EN undefined: ERASE and the prev storage SHALL be absent, every request SHALL go IDLE->DRAW->DONE, and BG_COLOUR is unused.

Verification
REQ-033 Reset, then one request (8,8,3'b101) with SIZE=2 -> cycles 1-4 plot (8,8),(9,8),(8,9),(9,9) in colour 101; done in cycle 5; req_ready high in cycle 6.
REQ-034 Erase enabled: request (8,8), then (10,8) -> second request plots (8,8),(9,8),(8,9),(9,9) in 011, then (10,8),(11,8),(10,9),(11,9) in 101; done 9 cycles after acceptance.
REQ-035 Request (127,119) with SIZE=2 -> only (127,119) is plotted; the other 3 cycles have pix_plot = 0; done still arrives 5 cycles after acceptance.
REQ-036 req_valid held high continuously with changing coordinates -> only values present in IDLE cycles are accepted; the spacing between acceptances is exactly SIZE*SIZE+2 cycles (no erase).
REQ-037 resetn pulsed low during the 2nd DRAW pixel -> pix_plot = 0 from the next cycle; no done; the next request performs no erase.
REQ-038 Build without BLOCK_PLOTTER_ERASE_PREV_EN, two requests back to back -> no BG_COLOUR writes; each done pulse arrives SIZE*SIZE+1 cycles after acceptance.
